seven_seg_bcd_converter: RTL and testbench
==========================================

# seven_seg_bcd_converter

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display interface. It takes a 16-bit unsigned binary value and produces four packed BCD digits on `bcd_out`, which connects straight to the display interface's 16-bit data input. The conversion uses a multi-cycle double-dabble (shift-and-add-3) engine with a start/busy/done handshake. `bcd_out` is registered and holds its value between conversions, so the display never shows intermediate values.

## Interface
Parameters: none.

- `clock_in`  input  1  system clock; all logic on the rising edge
- `reset`  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- `bin_in`  input  16  unsigned binary value; sampled only on the edge that accepts `start`
- `start`  input  1  conversion request; level-sampled, accepted only in IDLE
- `bcd_out`  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones; registered
- `busy`  output  1  high while a conversion is in progress
- `done`  output  1  one-cycle pulse; high in the cycle `bcd_out` first shows a new result
- `overflow`  output  1  registered; high when the last converted value was > 9999

## Operation
- Reset (`reset`=0 at an edge): state=IDLE; `bcd_out`=16'h0000, `busy`=0, `done`=0, `overflow`=0. Any conversion in flight is discarded.
- State machine:
  - IDLE: on `start`=1, load `bin_in` into a 16-bit shift register, clear the 20-bit BCD scratch (5 digits), set the iteration counter to 0, then go to SHIFT.
  - SHIFT: one iteration per cycle. Each scratch nibble ≥5 gets +3, then {scratch, shift} shifts left by 1. After 16 iterations (counter reaches 15), go to LOAD.
  - LOAD: update `bcd_out` and `overflow` from the scratch, pulse `done`, then return to IDLE.
- `busy`=1 in SHIFT and LOAD, 0 in IDLE.
- Overflow: `overflow`=1 when the ten-thousands digit (scratch[19:16]) is non-zero.
- `start` is ignored while `busy`=1, with no queueing. Changes to `bin_in` after acceptance have no effect.
- A `start` held high continuously re-triggers conversion every time IDLE is entered.

## Timing
- `start` is accepted at edge E0, and `busy`=1 after E0.
- SHIFT iterations occur at edges E1–E16.
- At E17, `bcd_out`, `overflow`, and `done` update; `busy` returns to 0. Latency from accept to valid output is 17 cycles.
- `done` falls at E18. The earliest next accept is E18, giving a maximum throughput of one conversion per 18 cycles.
- `bcd_out` changes only at the LOAD edge or on reset.
- Reset asserted at any edge overrides everything, including a simultaneous `start`.

## Configuration
- `SEVEN_SEG_SATURATE_EN` defined:
  - If the result is > 9999, `bcd_out`=16'h9999 and `overflow`=1.
- `SEVEN_SEG_SATURATE_EN` undefined:
  - `bcd_out`=scratch[15:0] (the lower four digits; the ten-thousands digit is dropped).
  - `overflow` still reports the condition.

## Test plan
- Reset, then `bin_in`=16'h04D2 (1234) with a one-cycle `start`: `busy` is high for 17 cycles; at E17, `bcd_out`=16'h1234, `done`=1 for exactly 1 cycle, `overflow`=0.
- `bin_in`=0, then 16'h270F (9999): `bcd_out`=16'h0000, then 16'h9999, with `overflow`=0 both times.
- `bin_in`=16'hFFFF (65535):
  - with `SEVEN_SEG_SATURATE_EN`, `bcd_out`=16'h9999 and `overflow`=1;
  - without it, `bcd_out`=16'h5535 and `overflow`=1.
- Convert 42 (→16'h0042). Then pulse `start` at E5 of a new 16'h1388 (5000) conversion with `bin_in`=7: the second `start` is ignored, the result is 16'h5000, and `done` pulses only once.
- Drive `reset`=0 at E8 of a 16'h04D2 conversion: all outputs are 0 on the next cycle and no `done` follows. A new `start` with 16'h0063 (99) gives 16'h0099 at E17.
- Hold `start`=1 continuously with `bin_in`=16'h000A (10): `done` pulses every 18 cycles, and `bcd_out`=16'h0010 stays stable between pulses.

Source files
------------

// File: rtl/seven_seg_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_bcd_converter
//  Purpose  : Sequential 16-bit binary to 4-digit packed BCD converter using
//             a shift-and-add-3 (double-dabble) engine, one iteration per
//             clock. Feeds the seven-segment display interface directly, so
//             the result register only changes when a conversion completes.
//  Ports    : clock_in  - system clock, rising edge
//             reset     - synchronous, active-low reset
//             bin_in    - unsigned binary value, sampled when start is accepted
//             start     - conversion request, level-sampled in IDLE only
//             bcd_out   - registered packed BCD {thousands,hundreds,tens,ones}
//             busy      - high while a conversion is in progress
//             done      - one-cycle pulse when bcd_out shows a new result
//             overflow  - registered, last converted value exceeded 9999
//  Config   : SEVEN_SEG_SATURATE_EN - when defined, results above 9999 are
//             shown as 9999; otherwise the ten-thousands digit is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_bcd_converter (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [15:0] bin_in,
   input  logic        start,
   output logic [15:0] bcd_out,
   output logic        busy,
   output logic        done,
   output logic        overflow
);

   localparam logic [3:0]  LAST_ITER = 4'd15;
   localparam logic [15:0] BCD_MAX   = 16'h9999;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   state_t      state_q,   state_d;
   logic [15:0] shift_q,   shift_d;
   logic [19:0] scratch_q, scratch_d;
   logic [3:0]  cnt_q,     cnt_d;
   logic [15:0] bcd_q,     bcd_d;
   logic        done_q,    done_d;
   logic        ovf_q,     ovf_d;

   logic [19:0] scratch_adj;
   logic        scratch_ovf;
   logic [15:0] load_value;

   // Add-3 correction applied to every BCD nibble before the shift, so a
   // digit that would reach 10+ after doubling carries into the next digit.
   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_digit_adj
         assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                       ? scratch_q[4*gi +: 4] + 4'd3
                                       : scratch_q[4*gi +: 4];
      end
   endgenerate

   assign scratch_ovf = |scratch_q[19:16];

`ifdef SEVEN_SEG_SATURATE_EN
   assign load_value = scratch_ovf ? BCD_MAX : scratch_q[15:0];
`else
   assign load_value = scratch_q[15:0];
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d   = bin_in;
               scratch_d = 20'd0;
               cnt_d     = 4'd0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // Scratch and shift register move together as one 36-bit word.
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bcd_d   = load_value;
            ovf_d   = scratch_ovf;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= 16'd0;
         scratch_q <= 20'd0;
         cnt_q     <= 4'd0;
         bcd_q     <= 16'd0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bcd_out  = bcd_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_bcd_converter
//  Purpose  : Self-checking bench for seven_seg_bcd_converter. A cycle-level
//             reference model (countdown + decimal arithmetic) predicts all
//             outputs; directed scenarios pin literal results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_bcd_converter;

   logic        clock_in = 1'b0;
   logic        reset    = 1'b0;
   logic [15:0] bin_in   = 16'd0;
   logic        start    = 1'b0;
   logic [15:0] bcd_out;
   logic        busy;
   logic        done;
   logic        overflow;

   seven_seg_bcd_converter dut (
      .clock_in (clock_in),
      .reset    (reset),
      .bin_in   (bin_in),
      .start    (start),
      .bcd_out  (bcd_out),
      .busy     (busy),
      .done     (done),
      .overflow (overflow)
   );

   always #5 clock_in = ~clock_in;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;
   bit chk_en = 1'b0;

   // Reference model state
   int          m_rem  = 0;
   logic [15:0] m_pend = 16'd0;
   logic [15:0] m_bcd  = 16'd0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_ovf  = 1'b0;

   function automatic logic [15:0] to_bcd(input logic [15:0] v);
      int x;
      x = int'(v);
      if (x > 9999) begin
`ifdef SEVEN_SEG_SATURATE_EN
         return 16'h9999;
`else
         x = x % 10000;
`endif
      end
      return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a conversion is a 17-cycle countdown ending in a result load.
   always @(posedge clock_in) begin
      if (!reset) begin
         m_rem  = 0;
         m_bcd  = 16'd0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_bcd  = to_bcd(m_pend);
               m_ovf  = (m_pend > 16'd9999);
               m_done = 1'b1;
               m_busy = 1'b0;
            end
         end else if (start) begin
            m_pend = bin_in;
            m_rem  = 17;
            m_busy = 1'b1;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clock_in) begin
      if (chk_en) begin
         check("bcd_out",  32'(bcd_out),  32'(m_bcd));
         check("busy",     32'(busy),     32'(m_busy));
         check("done",     32'(done),     32'(m_done));
         check("overflow", 32'(overflow), 32'(m_ovf));
         if (done === 1'b1) n_done++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   // Waits for done; t returns negedges elapsed (-1 on timeout).
   task automatic wait_done(output int t);
      t = 0;
      while (done !== 1'b1 && t < 40) begin
         cyc(1);
         t++;
      end
      if (done !== 1'b1) begin
         check("done_timeout", 32'(done), 32'd1);
         t = -1;
      end
   endtask

   task automatic convert(input logic [15:0] v, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input string name);
      int t;
      bin_in = v;
      start  = 1'b1;
      cyc(1);
      start  = 1'b0;
      bin_in = 16'($urandom);
      wait_done(t);
      check({name, "_latency"}, 32'(t), 32'd17);
      check({name, "_bcd"},     32'(bcd_out), 32'(exp_bcd));
      check({name, "_ovf"},     32'(overflow), 32'(exp_ovf));
      cyc(1);
   endtask

   initial begin
      int t;
      int d0;
      int prev;

      reset = 1'b0;
      cyc(2);
      chk_en = 1'b1;
      check("rst_bcd",  32'(bcd_out), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_ovf",  32'(overflow), 32'h0);
      reset = 1'b1;
      cyc(2);

      // Literal pins on the model itself
      check("model_1234",  32'(to_bcd(16'd1234)), 32'h1234);
      check("model_42",    32'(to_bcd(16'd42)),   32'h0042);

      convert(16'h04D2, 16'h1234, 1'b0, "c1234");
      convert(16'h0000, 16'h0000, 1'b0, "c0");
      convert(16'h270F, 16'h9999, 1'b0, "c9999");
`ifdef SEVEN_SEG_SATURATE_EN
      convert(16'hFFFF, 16'h9999, 1'b1, "cffff");
`else
      convert(16'hFFFF, 16'h5535, 1'b1, "cffff");
`endif
      convert(16'd10000, to_bcd(16'd10000), 1'b1, "c10000");
      convert(16'd42, 16'h0042, 1'b0, "c42");

      // Start pulsed mid-conversion must be ignored
      d0     = n_done;
      bin_in = 16'h1388;
      start  = 1'b1;
      cyc(1);
      start  = 1'b0;
      cyc(4);
      bin_in = 16'd7;
      start  = 1'b1;
      cyc(1);
      start  = 1'b0;
      wait_done(t);
      check("ign_bcd", 32'(bcd_out), 32'h5000);
      cyc(30);
      check("ign_done_once", 32'(n_done - d0), 32'd1);

      // Reset in the middle of a conversion
      bin_in = 16'h04D2;
      start  = 1'b1;
      cyc(1);
      start  = 1'b0;
      cyc(7);
      reset  = 1'b0;
      cyc(1);
      reset  = 1'b1;
      check("midrst_bcd",  32'(bcd_out), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_ovf",  32'(overflow), 32'h0);
      d0 = n_done;
      cyc(25);
      check("midrst_nodone", 32'(n_done - d0), 32'd0);
      convert(16'h0063, 16'h0099, 1'b0, "c99");

      // Continuous start: one result every 18 cycles
      bin_in = 16'h000A;
      start  = 1'b1;
      wait_done(t);
      for (int k = 0; k < 3; k++) begin
         prev = 0;
         cyc(1);
         prev = 1;
         while (done !== 1'b1 && prev < 40) begin
            check("hold_stable", 32'(bcd_out), 32'h0010);
            cyc(1);
            prev++;
         end
         check("hold_period", 32'(prev), 32'd18);
      end
      start = 1'b0;
      cyc(20);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bin_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(9990, 10010))
                                               : 16'($urandom);
         start  = ($urandom_range(0, 3) == 0);
         reset  = ($urandom_range(0, 150) != 0);
         cyc(1);
      end
      reset = 1'b1;
      start = 1'b0;
      cyc(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
